// File: rtl/alu_exec_if.sv
// Handshake/data bundle between the control FSM and the alu_exec execution unit.
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            alu_en;
    logic [7:0]      alu_op;
    logic [1:0]      op2_dir;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            done;

    modport master (
        output alu_en, alu_op, op2_dir, instr, rs1_data, rs2_data,
        input  result, busy, done
    );

    modport slave (
        input  alu_en, alu_op, op2_dir, instr, rs1_data, rs2_data,
        output result, busy, done
    );
endinterface

// File: rtl/alu_exec.sv
// Execution unit: single-cycle ALU ops plus iterative shift-add MUL and restoring DIV.
// Optional: define ALU_EXEC_FAST_MUL_EN to make MUL a single-cycle combinational multiply.
module alu_exec #(
    parameter int XLEN           = 32,
    parameter int MUL_DIV_CYCLES = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_exec_if.slave bus
);
    localparam int CNT_W = $clog2(MUL_DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_DIV_CYCLES - 1);

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_ADDI = 8'd1;
    localparam logic [7:0] OP_SUB  = 8'd2;
    localparam logic [7:0] OP_MUL  = 8'd3;
    localparam logic [7:0] OP_DIV  = 8'd4;
    localparam logic [7:0] OP_SLL  = 8'd5;
    localparam logic [7:0] OP_SRL  = 8'd6;
    localparam logic [7:0] OP_AND  = 8'd7;
    localparam logic [7:0] OP_OR   = 8'd8;
    localparam logic [7:0] OP_NOT  = 8'd9;
    localparam logic [7:0] OP_XOR  = 8'd10;
    localparam logic [7:0] OP_LUI  = 8'd11;

    typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, DONE} state_t;

    state_t                 state, state_nxt;
    logic [XLEN-1:0]        result_r;
    logic [XLEN-1:0]        acc;
    logic [XLEN-1:0]        opa;
    logic [XLEN-1:0]        opb;
    logic [CNT_W-1:0]       cnt;
    logic                   neg;

    logic [XLEN-1:0]        op2;
    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] op2_s;
    logic                   start_mul;
    logic                   start_div;
    logic                   last;
    logic [XLEN-1:0]        mul_acc_nxt;
    logic [XLEN-1:0]        div_shift;
    logic                   div_ge;
    logic [XLEN-1:0]        div_rem_nxt;
    logic [XLEN-1:0]        div_q_nxt;
    logic                   unused_instr;

    function automatic logic [XLEN-1:0] sel_op2(input logic [1:0]      dir,
                                                input logic [XLEN-1:0] ins,
                                                input logic [XLEN-1:0] rs2);
        case (dir)
            2'b00:   sel_op2 = rs2;
            2'b01:   sel_op2 = {ins[XLEN-1:12], 12'b0};
            2'b10:   sel_op2 = {{(XLEN-12){ins[XLEN-1]}}, ins[XLEN-1:XLEN-12]};
            default: sel_op2 = '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v);
        mag = v[XLEN-1] ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] m, input logic n);
        apply_sign = n ? -m : m;
    endfunction

    function automatic logic [XLEN-1:0] alu_single(input logic [7:0]      op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        case (op)
            OP_ADD, OP_ADDI: alu_single = a + b;
            OP_SUB:          alu_single = a - b;
`ifdef ALU_EXEC_FAST_MUL_EN
            OP_MUL:          alu_single = a * b;
`endif
            OP_SLL:          alu_single = a << b[4:0];
            OP_SRL:          alu_single = a >> b[4:0];
            OP_AND:          alu_single = a & b;
            OP_OR:           alu_single = a | b;
            OP_NOT:          alu_single = ~a;
            OP_XOR:          alu_single = a ^ b;
            OP_LUI:          alu_single = b;
            default:         alu_single = '0;
        endcase
    endfunction

    assign op2          = sel_op2(bus.op2_dir, bus.instr, bus.rs2_data);
    assign rs1_s        = bus.rs1_data;
    assign op2_s        = op2;
    assign unused_instr = ^bus.instr[11:0];
`ifdef ALU_EXEC_FAST_MUL_EN
    assign start_mul    = 1'b0;
`else
    assign start_mul    = (bus.alu_op == OP_MUL);
`endif
    assign start_div    = (bus.alu_op == OP_DIV);
    assign last         = (cnt == CNT_LAST);

    // One multiplier bit per cycle: opa walks left, opb walks right.
    assign mul_acc_nxt  = acc + (opb[0] ? opa : '0);
    // Restoring step: remainder in acc, dividend shifting out of opa into quotient bits.
    assign div_shift    = {acc[XLEN-2:0], opa[XLEN-1]};
    assign div_ge       = (div_shift >= opb);
    assign div_rem_nxt  = div_ge ? (div_shift - opb) : div_shift;
    assign div_q_nxt    = {opa[XLEN-2:0], div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.alu_en) begin
                    if (start_mul)      state_nxt = MUL_ITER;
                    else if (start_div) state_nxt = DIV_ITER;
                    else                state_nxt = DONE;
                end
            end
            MUL_ITER: if (last) state_nxt = DONE;
            DIV_ITER: if (opb == '0 || last) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.alu_en) begin
                        if (start_mul) begin
                            acc <= '0;
                            opa <= bus.rs1_data;
                            opb <= op2;
                            cnt <= '0;
                        end else if (start_div) begin
                            acc <= '0;
                            opa <= mag(rs1_s);
                            opb <= mag(op2_s);
                            neg <= rs1_s[XLEN-1] ^ op2_s[XLEN-1];
                            cnt <= '0;
                        end else begin
                            result_r <= alu_single(bus.alu_op, bus.rs1_data, op2);
                        end
                    end
                end
                MUL_ITER: begin
                    acc <= mul_acc_nxt;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (last) result_r <= mul_acc_nxt;
                end
                DIV_ITER: begin
                    if (opb == '0) begin
                        result_r <= '1;
                    end else begin
                        acc <= div_rem_nxt;
                        opa <= div_q_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last) result_r <= apply_sign(div_q_nxt, neg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.busy   = (state == MUL_ITER) || (state == DIV_ITER);
    assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: cycle-level reference model plus directed vectors.
module tb_alu_exec;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(32)) bus_if ();

    alu_exec #(.XLEN(32), .MUL_DIV_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

`ifdef ALU_EXEC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] op2_of(input logic [1:0] dir, input logic [31:0] ins,
                                           input logic [31:0] rs2);
        case (dir)
            2'b00:   return rs2;
            2'b01:   return {ins[31:12], 12'h000};
            2'b10:   return 32'(int'(ins) >>> 20);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] res_of(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            8'd0, 8'd1: return a + b;
            8'd2:       return a - b;
            8'd3:       return a * b;
            8'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(int'(a) / int'(b));
            end
            8'd5:       return a << b[4:0];
            8'd6:       return a >> b[4:0];
            8'd7:       return a & b;
            8'd8:       return a | b;
            8'd9:       return ~a;
            8'd10:      return a ^ b;
            8'd11:      return b;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input logic [7:0] op, input logic [31:0] b);
        if (op == 8'd3) return MUL_LAT;
        if (op == 8'd4) return (b == 32'h0) ? 2 : 33;
        return 1;
    endfunction

    logic        exp_busy, exp_done;
    logic [31:0] exp_result, pend;
    int          m_left;

    // Reference model: m_left counts edges until the outcome becomes visible.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_busy   <= 1'b0;
            exp_done   <= 1'b0;
            exp_result <= 32'h0;
            pend       <= 32'h0;
            m_left     <= 0;
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
        end else if (m_left == 1) begin
            m_left     <= 0;
            exp_busy   <= 1'b0;
            exp_done   <= 1'b1;
            exp_result <= pend;
        end else if (exp_done) begin
            exp_done <= 1'b0;
        end else if (bus_if.alu_en) begin
            if (lat_of(bus_if.alu_op, op2_of(bus_if.op2_dir, bus_if.instr, bus_if.rs2_data)) == 1) begin
                exp_done   <= 1'b1;
                exp_result <= res_of(bus_if.alu_op, bus_if.rs1_data,
                                     op2_of(bus_if.op2_dir, bus_if.instr, bus_if.rs2_data));
            end else begin
                exp_busy <= 1'b1;
                m_left   <= lat_of(bus_if.alu_op,
                                   op2_of(bus_if.op2_dir, bus_if.instr, bus_if.rs2_data)) - 1;
                pend     <= res_of(bus_if.alu_op, bus_if.rs1_data,
                                   op2_of(bus_if.op2_dir, bus_if.instr, bus_if.rs2_data));
            end
        end
    end

    always begin
        @(negedge clk);
        if (rst_n) begin
            chk("busy", {31'b0, bus_if.busy}, {31'b0, exp_busy});
            chk("done", {31'b0, bus_if.done}, {31'b0, exp_done});
            chk("result", bus_if.result, exp_result);
            if (bus_if.done) done_cnt++;
        end
    end

    task automatic start_op(input logic [7:0] op, input logic [1:0] dir, input logic [31:0] ins,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus_if.alu_en   = 1'b1;
        bus_if.alu_op   = op;
        bus_if.op2_dir  = dir;
        bus_if.instr    = ins;
        bus_if.rs1_data = a;
        bus_if.rs2_data = b;
        @(negedge clk);
        bus_if.alu_en   = 1'b0;
        bus_if.alu_op   = 8'($urandom_range(0, 15));
        bus_if.instr    = $urandom;
        bus_if.rs1_data = $urandom;
        bus_if.rs2_data = $urandom;
    endtask

    task automatic wait_done(inout int lat);
        while (!bus_if.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] op, input logic [1:0] dir,
                          input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        start_op(op, dir, ins, a, b);
        lat = 1;
        wait_done(lat);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_res"}, bus_if.result, exp_res);
    endtask

    initial begin
        int d0;
        int lat;
        bus_if.alu_en   = 1'b0;
        bus_if.alu_op   = 8'd0;
        bus_if.op2_dir  = 2'b00;
        bus_if.instr    = 32'h0;
        bus_if.rs1_data = 32'h0;
        bus_if.rs2_data = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", bus_if.result, 32'h0);
        chk("rst_busy", {31'b0, bus_if.busy}, 32'h0);
        chk("rst_done", {31'b0, bus_if.done}, 32'h0);
        rst_n = 1'b1;

        run_op("addi", 8'd1, 2'b10, 32'hFFD0_0000, 32'd5, 32'h0000_DEAD, 32'd2, 1);
        run_op("lui", 8'd11, 2'b01, 32'h1234_5ABC, 32'h7777_7777, 32'h0, 32'h1234_5000, 1);

        // Abort an in-flight MUL with reset; the held LUI result must clear.
        start_op(8'd3, 2'b00, 32'h0, 32'hFFFF_FFFD, 32'd7);
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", bus_if.result, 32'h0);
        chk("abort_busy", {31'b0, bus_if.busy}, 32'h0);
        chk("abort_done", {31'b0, bus_if.done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));

        run_op("mul", 8'd3, 2'b00, 32'h0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, MUL_LAT);
        run_op("div_neg", 8'd4, 2'b00, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("div_zero", 8'd4, 2'b00, 32'h0, 32'd7, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("div_ovf", 8'd4, 2'b00, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("div_iimm", 8'd4, 2'b10, 32'hFFE0_0000, 32'd7, 32'h0, 32'hFFFF_FFFD, 33);
        run_op("sll", 8'd5, 2'b00, 32'h0, 32'd1, 32'h23, 32'h8, 1);
        run_op("srl", 8'd6, 2'b00, 32'h0, 32'h8000_0000, 32'd31, 32'h1, 1);
        run_op("sub", 8'd2, 2'b00, 32'h0, 32'd3, 32'd10, 32'hFFFF_FFF9, 1);
        run_op("and", 8'd7, 2'b00, 32'h0, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'h00F0_0F00, 1);
        run_op("or", 8'd8, 2'b00, 32'h0, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1);
        run_op("xor", 8'd10, 2'b00, 32'h0, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'hFF00_F0F0, 1);
        run_op("not", 8'd9, 2'b00, 32'h0, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1);
        run_op("add_zero", 8'd0, 2'b11, 32'h0, 32'd9, 32'd100, 32'd9, 1);
        run_op("undef_op", 8'd12, 2'b00, 32'h0, 32'd9, 32'd100, 32'h0, 1);

        // A start request while DIV 100/7 is in flight must be dropped.
        start_op(8'd4, 2'b00, 32'h0, 32'd100, 32'd7);
        d0  = done_cnt;
        lat = 1;
        repeat (8) @(negedge clk);
        lat += 8;
        bus_if.alu_en   = 1'b1;
        bus_if.alu_op   = 8'd0;
        bus_if.op2_dir  = 2'b00;
        bus_if.rs1_data = 32'd1;
        bus_if.rs2_data = 32'd1;
        @(negedge clk);
        bus_if.alu_en = 1'b0;
        lat++;
        wait_done(lat);
        chk("busy_prot_lat", 32'(lat), 32'd33);
        chk("busy_prot_res", bus_if.result, 32'd14);
        repeat (5) @(negedge clk);
        chk("busy_prot_one_done", 32'(done_cnt), 32'(d0 + 1));
        chk("busy_prot_hold", bus_if.result, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit directly downstream of the CPU control FSM.
- Consumes the FSM's alu_en / alu_op / op2_dir along with register-file read data and the current instruction word.
- Produces a registered 32-bit result for the register-file write-back path.
- Single-cycle ops finish in one clock; MUL/DIV run iteratively and report completion with busy/done.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- MUL_DIV_CYCLES, 32, iteration count for MUL and DIV (must equal XLEN)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_en  input  1  start request, sampled only in IDLE
- alu_op  input  8  operation: 0 ADD, 1 ADDI, 2 SUB, 3 MUL, 4 DIV, 5 SLL, 6 SRL, 7 AND, 8 OR, 9 NOT, 10 XOR, 11 LUI
- op2_dir  input  2  operand-2 select: 00 rs2_data, 01 U-imm, 10 I-imm, 11 zero
- instr  input  32  current instruction word (immediate source)
- rs1_data  input  32  operand 1
- rs2_data  input  32  register operand 2
- result  output  32  registered result; held until next accepted start
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse when result becomes valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result=0, busy=0, done=0, all internal operands/counters 0.
- Operand 2 is captured at start:
  - U-imm = {instr[31:12],12'b0}
  - I-imm = sign-extended instr[31:20]
- States: IDLE, MUL_ITER, DIV_ITER, DONE.
- IDLE:
  - alu_en=1 with a single-cycle op (0-2, 5-11) -> result written at that edge, go to DONE.
  - alu_en=1 with op 3 -> latch operands, counter=0, busy=1, go to MUL_ITER.
  - alu_en=1 with op 4 -> latch operands, counter=0, busy=1, go to DIV_ITER.
- Single-cycle ops:
  - ADD/ADDI: op1+op2, mod 2^32.
  - SUB: op1-op2, mod 2^32.
  - SLL/SRL: logical shift of op1 by op2[4:0].
  - AND/OR/XOR: bitwise.
  - NOT: ~op1, op2 ignored.
  - LUI: result = op2.
- MUL_ITER: radix-2 shift-add, one bit per cycle, 32 cycles, then DONE. Result = low 32 bits of the product (sign-agnostic).
- DIV_ITER: signed restoring division on magnitudes, 32 cycles, then DONE.
  - Quotient sign = sign(op1) XOR sign(op2); quotient rounds toward zero.
  - Divide by zero: no iteration, go to DONE next cycle, result=32'hFFFF_FFFF.
  - Overflow (32'h8000_0000 / -1): result=32'h8000_0000, via normal iteration or a short-cut (either allowed; latency must match the stated total).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. result stays stable until the next accepted start.
- Latency, counted from the start edge to the done-high cycle:
  - Single-cycle ops: 1.
  - MUL/DIV: 33.
  - Divide by zero: 2.
- alu_en in MUL_ITER, DIV_ITER or DONE is ignored; there is no queuing.
- Undefined alu_op (>11): result=0, treated as a single-cycle op.
- rs1_data, rs2_data and instr may change after the start edge without affecting an in-flight operation.
- Reset asserted mid-operation aborts immediately. No done pulse is produced for the aborted op.

Optional Feature:
- Macro ALU_EXEC_FAST_MUL_EN.
- When defined: MUL is a single-cycle op using a combinational 32x32 multiply; latency 1, busy never asserts for MUL.
- When undefined: the iterative 33-cycle MUL above.
- DIV is unaffected in both cases.

Test Plan:
- Reset: hold rst_n=0 mid-MUL, release -> result=0, busy=0, done=0, state IDLE; no stray done pulse.
- ADDI: rs1=5, instr[31:20]=12'hFFD, op2_dir=10, alu_en one cycle -> done after 1 cycle, result=2. Repeat with LUI, instr[31:12]=20'h12345, op2_dir=01 -> result=32'h1234_5000.
- MUL: rs1=32'hFFFF_FFFD (-3), rs2=7 -> busy for 32 cycles, done at cycle 33, result=32'hFFFF_FFEB. Under ALU_EXEC_FAST_MUL_EN -> done at cycle 1, same result.
- DIV: -7/2 -> result=32'hFFFF_FFFD. 7/0 -> result=32'hFFFF_FFFF with done at cycle 2. 32'h8000_0000/-1 -> result=32'h8000_0000.
- Busy protection: start DIV 100/7, pulse alu_en with ADD at cycle 10 -> ADD ignored, result=14, single done pulse.
- Shifts: SLL rs1=1, rs2=32'h23 -> 32'h8; SRL rs1=32'h8000_0000, rs2=31 -> 1.
